ringosc_freq_ctrl: RTL and testbench

Measurement sequencer for the inverter-chain ring oscillator. On command it enables the ring, waits a settle interval, and selects one of the chain's tap outputs. It then counts that tap's rising edges over a programmable gate window of `clk` cycles and reports the count. It sits between the host-side control inputs and the ring: it drives the ring enable and consumes the asynchronous tap outputs.

---
 rtl/ringosc_freq_ctrl.sv | 127 ++++++++++++
 tb/tb_ringosc_freq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ringosc_freq_ctrl.sv
// Ring-oscillator measurement sequencer: enables the ring, settles, then counts
// rising edges of one synchronized tap over a programmable gate window.
//
// state   | meaning
// IDLE    | ring off, waiting for start
// SETTLE  | ring on, letting the chain stabilise
// MEASURE | ring on, counting edges of the selected tap
// DONE    | one-cycle result strobe, ring off
module ringosc_freq_ctrl #(
  parameter int NUM_TAPS      = 16,
  localparam int SEL_W        = $clog2(NUM_TAPS),
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    tap_sel,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic [NUM_TAPS-1:0] taps_in,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [ST_W-1:0]     settle_cnt_q;
  logic                s1, s2, s3;
  logic [CNT_W-1:0]    live_cnt_q;
  logic                live_ovf_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;
  logic                start_acc;
  logic                tap_ok;
  logic                edge_det;

  assign start_acc = (state_q == IDLE) && start;
  assign tap_ok    = int'(tap_sel) < NUM_TAPS;
  assign edge_det  = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (abort) state_d = IDLE;
               else if (settle_cnt_q == '0) state_d = MEASURE;
      MEASURE: if (abort) state_d = IDLE;
               else if (gate_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ring_en  = (state_q == SETTLE) || (state_q == MEASURE);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    // Live counter is frozen in DONE, so present it directly alongside the strobe.
    count    = (state_q == DONE) ? live_cnt_q : count_q;
    overflow = (state_q == DONE) ? live_ovf_q : ovf_q;
  end

  // Down-counters hold (length - 1) and terminate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      gate_cnt_q   <= '0;
      settle_cnt_q <= '0;
      live_cnt_q   <= '0;
      live_ovf_q   <= 1'b0;
    end else if (start_acc) begin
      sel_q        <= tap_ok ? tap_sel : '0;
      gate_cnt_q   <= (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
      settle_cnt_q <= ST_W'(SETTLE_CYCLES - 1);
      live_cnt_q   <= '0;
      live_ovf_q   <= 1'b0;
    end else begin
      if (state_q == SETTLE && settle_cnt_q != '0)
        settle_cnt_q <= settle_cnt_q - ST_W'(1);
      if (state_q == MEASURE && gate_cnt_q != '0)
        gate_cnt_q <= gate_cnt_q - GATE_W'(1);
      if (state_q == MEASURE && edge_det) begin
        if (&live_cnt_q) live_ovf_q <= 1'b1;
        else             live_cnt_q <= live_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == DONE) begin
      count_q <= live_cnt_q;
      ovf_q   <= live_ovf_q;
    end
  end

  // Free-running synchronizer; s3 is the history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= taps_in[sel_q];
      s2 <= s1;
      s3 <= s2;
    end
  end

endmodule

// File: tb/tb_ringosc_freq_ctrl.sv
// Bench for ringosc_freq_ctrl: two instances (wide and 4-bit counter) share stimulus;
// results are compared against a sampled-history edge model.
module tb_ringosc_freq_ctrl;
  localparam int NT = 18;
  localparam int SW = 5;
  localparam int GW = 16;
  localparam int S  = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [SW-1:0] tap_sel = '0;
  logic [GW-1:0] gate_len = '0;
  logic [NT-1:0] taps_in = '0;
  logic          ring_en_a, busy_a, done_a, ovf_a;
  logic [23:0]   count_a;
  logic          ring_en_b, busy_b, done_b, ovf_b;
  logic [3:0]    count_b;

  ringosc_freq_ctrl #(.NUM_TAPS(NT), .GATE_W(GW), .CNT_W(24), .SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tap_sel(tap_sel),
    .gate_len(gate_len), .taps_in(taps_in), .ring_en(ring_en_a), .busy(busy_a),
    .done(done_a), .count(count_a), .overflow(ovf_a));

  ringosc_freq_ctrl #(.NUM_TAPS(NT), .GATE_W(GW), .CNT_W(4), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tap_sel(tap_sel),
    .gate_len(gate_len), .taps_in(taps_in), .ring_en(ring_en_b), .busy(busy_b),
    .done(done_b), .count(count_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [NT-1:0] hist [0:65535];
  int hp [NT];
  int ph [NT];

  always @(posedge clk) begin
    hist[cyc] <= taps_in;
    cyc <= cyc + 1;
  end

  // Tap i toggles every hp[i] clk cycles; hp of 0 holds the tap static.
  always @(negedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (hp[i] != 0) begin
        if (ph[i] >= hp[i] - 1) begin
          taps_in[i] = ~taps_in[i];
          ph[i] = 0;
        end else ph[i]++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Rising transitions between consecutive clk samples of the chosen tap inside the
  // window shifted two cycles earlier than the gate (synchronizer latency).
  function automatic int model_edges(input int k, input int sel, input int gate);
    int es = (sel >= NT) ? 0 : sel;
    int g  = (gate == 0) ? 1 : gate;
    int n  = 0;
    for (int j = k + S - 2; j <= k + S + g - 3; j++)
      if (hist[j+1][es] === 1'b1 && hist[j][es] === 1'b0) n++;
    return n;
  endfunction

  int run_k, run_lat, run_ren, run_nd, run_ca, run_oa, run_cb, run_ob;

  task automatic do_run(input int sel, input int gate, input bit poke, input bit ab);
    @(negedge clk);
    tap_sel = SW'(sel); gate_len = GW'(gate); start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    run_k = cyc - 1; run_lat = -1; run_ren = 0; run_nd = 0;
    run_ca = -1; run_oa = -1; run_cb = -1; run_ob = -1;
    for (int i = 0; i < 2000; i++) begin
      if (ring_en_a) run_ren++;
      if (done_a) begin
        run_nd++;
        if (run_lat < 0) begin
          run_lat = cyc - run_k;
          run_ca = int'(count_a); run_oa = int'(ovf_a);
          run_cb = int'(count_b); run_ob = int'(ovf_b);
        end
      end
      if (!busy_a) begin start = 1'b0; break; end
      if (poke) begin
        start = (i % 5 == 2);
        if (start) begin
          tap_sel = SW'($urandom_range(0, 31));
          gate_len = GW'($urandom_range(0, 2000));
        end
      end
      @(negedge clk);
    end
    start = 1'b0; tap_sel = SW'(sel); gate_len = GW'(gate);
    chk("busy_end", int'(busy_a), 0);
  endtask

  task automatic check_run(input string tag, input int sel, input int gate);
    int m  = model_edges(run_k, sel, gate);
    int g  = (gate == 0) ? 1 : gate;
    chk({tag, " count_model"}, run_ca, m);
    chk({tag, " ovf_a"}, run_oa, 0);
    chk({tag, " latency"}, run_lat, S + g + 1);
    chk({tag, " ring_en_cycles"}, run_ren, S + g);
    chk({tag, " done_pulses"}, run_nd, 1);
    chk({tag, " count_b_sat"}, run_cb, (m > 15) ? 15 : m);
    chk({tag, " ovf_b"}, run_ob, (m > 15) ? 1 : 0);
    chk({tag, " count_hold"}, int'(count_a), run_ca);
  endtask

  typedef struct {int sel; int gate; int lo; int hi; int lat; bit ab;} vec_t;
  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, sel, gate;
    tbl[0] = '{3, 800, 99, 101, 817, 1'b0};
    tbl[1] = '{7, 0, 0, 0, 18, 1'b0};
    tbl[2] = '{15, 400, 99, 101, 417, 1'b0};
    tbl[3] = '{20, 400, 39, 41, 417, 1'b0};
    tbl[4] = '{15, 100, 24, 26, 117, 1'b0};
    tbl[5] = '{15, 8, 1, 3, 25, 1'b1};
    tbl[6] = '{3, 1, 0, 1, 18, 1'b0};
    tbl[7] = '{19, 60, 5, 7, 77, 1'b0};
    hp[0] = 5; hp[3] = 4; hp[15] = 2;

    repeat (3) @(negedge clk);
    chk("rst ring_en", int'(ring_en_a), 0);
    chk("rst busy", int'(busy_a), 0);
    chk("rst done", int'(done_a), 0);
    chk("rst count", int'(count_a), 0);
    chk("rst overflow", int'(ovf_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      do_run(tbl[r].sel, tbl[r].gate, 1'b0, tbl[r].ab);
      chk_rng($sformatf("row%0d count_range", r), run_ca, tbl[r].lo, tbl[r].hi);
      chk($sformatf("row%0d latency_tbl", r), run_lat, tbl[r].lat);
      check_run($sformatf("row%0d", r), tbl[r].sel, tbl[r].gate);
    end

    // Abort in the 10th MEASURE cycle.
    prev = int'(count_a);
    @(negedge clk);
    tap_sel = 5'd3; gate_len = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort pre ring_en", int'(ring_en_a), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(busy_a), 0);
    chk("abort ring_en", int'(ring_en_a), 0);
    chk("abort count_kept", int'(count_a), prev);
    run_nd = 0;
    repeat (60) begin
      if (done_a) run_nd++;
      @(negedge clk);
    end
    chk("abort no_done", run_nd, 0);
    chk("abort count_after", int'(count_a), prev);

    // Start pulses while busy must not restart or add a done.
    do_run(3, 30, 1'b1, 1'b0);
    check_run("poke", 3, 30);

    // Asynchronous reset during MEASURE.
    @(negedge clk);
    tap_sel = 5'd3; gate_len = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ring_en", int'(ring_en_a), 0);
    chk("midrst busy", int'(busy_a), 0);
    chk("midrst count", int'(count_a), 0);
    chk("midrst overflow", int'(ovf_a), 0);
    chk("midrst done", int'(done_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(3, 40, 1'b0, 1'b0);
    check_run("post_rst", 3, 40);

    // Randomized tap frequencies, selections and gate lengths.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NT; i++) hp[i] = $urandom_range(0, 7);
      sel  = $urandom_range(0, 31);
      gate = $urandom_range(0, 300);
      do_run(sel, gate, r[0], 1'b0);
      check_run($sformatf("rand%0d", r), sel, gate);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
